// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: LSB-first shifting with a one-word holding
// buffer so back-to-back words stream without idle bits.
module piso_tx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;
    logic             done_q, done_d;
    logic             accept;

    assign accept = load_valid && load_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            hold_full_q <= hold_full_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sreg_d  = data;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (shift_en && cnt_q == LAST) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    if (hold_full_q) begin
                        sreg_d      = hold_q;
                        hold_full_d = 1'b0;
                        if (accept) begin
                            hold_d      = data;
                            hold_full_d = 1'b1;
                        end
                    end else if (accept) begin
                        // Bypass the empty hold so the new word follows with no gap.
                        sreg_d = data;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (shift_en) begin
                        sreg_d = sreg_q >> 1;
                        cnt_d  = cnt_q + CW'(1);
                    end
                    if (accept) begin
                        hold_d      = data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign load_ready = reset && !hold_full_q;
    assign sout       = sreg_q[0];
    assign sout_valid = (state_q == StShift);
    assign frame      = (state_q == StShift) && (cnt_q == '0);
    assign done       = done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: accepted words are expanded into an expected bit
// stream; a negedge monitor compares every presented bit, frame, done and ready.
module tb_piso_tx;

    localparam int unsigned WIDTH = 4;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] data;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             frame;
    logic             done;

    piso_tx #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .data       (data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .sout       (sout),
        .sout_valid (sout_valid),
        .frame      (frame),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic b;
        logic first;
        logic last;
        int   wid;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   word_id  = 0;
    int   bits_pushed = 0;
    int   bits_popped = 0;
    logic pending_done = 1'b0;

    function automatic void chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endfunction

    // Hold is full exactly when the model holds bits of two different words.
    function automatic logic exp_ready();
        if (q.size() == 0) return 1'b1;
        return q[0].wid == q[q.size()-1].wid;
    endfunction

    // Monitor: runs mid-cycle, after inputs for the coming edge are settled.
    always @(negedge clock) begin
        if (reset) begin
            chk("done", done, pending_done);
            chk("load_ready", load_ready, exp_ready());
            chk("sout_valid", sout_valid, q.size() > 0);
            pending_done = 1'b0;
            if (q.size() > 0) begin
                chk("sout", sout, q[0].b);
                chk("frame", frame, q[0].first);
                if (shift_en) begin
                    pending_done = q[0].last;
                    void'(q.pop_front());
                    bits_popped++;
                end
            end
        end
    end

    // One cycle: inputs set just after an edge, handshake evaluated just before the next.
    task automatic step(input logic lv, input logic [WIDTH-1:0] d, input logic se,
                        output logic took);
        logic rdy;
        load_valid = lv;
        data       = d;
        shift_en   = se;
        #8;
        rdy = load_ready;
        @(posedge clock);
        took = lv && rdy;
        if (took) begin
            for (int i = 0; i < WIDTH; i++) begin
                q.push_back('{b: d[i], first: (i == 0), last: (i == WIDTH - 1), wid: word_id});
                bits_pushed++;
            end
            word_id++;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic se);
        logic t;
        for (int i = 0; i < n; i++) step(1'b0, '0, se, t);
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic se);
        logic t;
        int   k;
        t = 1'b0;
        k = 0;
        while (!t && k < 50) begin
            step(1'b1, d, se, t);
            k++;
        end
        if (!t) begin
            n_checks++;
            $display("FAIL send_timeout: word %h not accepted within %0d cycles", d, k);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_sout", sout, 1'b0);
        chk("rst_sout_valid", sout_valid, 1'b0);
        chk("rst_frame", frame, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_load_ready", load_ready, 1'b0);
    endtask

    initial begin
        logic t;
        reset      = 1'b0;
        data       = '0;
        load_valid = 1'b0;
        shift_en   = 1'b0;
        #2;
        check_reset_outputs();
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("ready_after_reset", load_ready, 1'b1);

        // Single word, continuous shifting.
        send(4'b1011, 1'b1);
        idle(6, 1'b1);

        // Stall after bit 1.
        step(1'b1, 4'b1011, 1'b1, t);
        step(1'b0, '0, 1'b0, t);
        step(1'b0, '0, 1'b0, t);
        idle(6, 1'b1);

        // Streaming three words.
        send(4'hA, 1'b1);
        send(4'h5, 1'b1);
        send(4'hF, 1'b1);
        idle(14, 1'b1);

        // Backpressure: hold full with shifting stalled.
        send(4'h3, 1'b0);
        send(4'hC, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 4'h7, 1'b0, t);
        idle(12, 1'b1);

        // Bypass on the last-bit edge.
        send(4'h9, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 4'h6, 1'b1, t);
        idle(6, 1'b1);

        // Reset mid-stream.
        send(4'hE, 1'b1);
        send(4'h2, 1'b1);
        step(1'b0, '0, 1'b1, t);
        reset = 1'b0;
        #1;
        check_reset_outputs();
        q.delete();
        pending_done = 1'b0;
        idle(2, 1'b1);
        reset = 1'b1;
        #1;
        chk("ready_after_midreset", load_ready, 1'b1);
        send(4'h4, 1'b1);
        idle(6, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) != 0), t);
        end
        idle(20, 1'b1);

        n_checks++;
        if (q.size() == 0 && bits_popped > 0) n_pass++;
        else $display("FAIL drain: %0d bits left, %0d of %0d consumed",
                      q.size(), bits_popped, bits_pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter: accepts WIDTH-bit words on a valid/ready handshake and shifts them out LSB-first, one bit per enabled clock, with a one-word holding buffer so consecutive words stream with no idle bit between them. It is the serialising end of the 4-bit register datapath: it feeds the serial link whose far end rebuilds parallel words.

## Interface
- WIDTH, 4, bits per word (≥2)
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- data  input  WIDTH  parallel word to send
- load_valid  input  1  data valid this cycle
- load_ready  output  1  word accepted when load_valid && load_ready at a clock edge
- shift_en  input  1  consume current serial bit this cycle
- sout  output  1  current serial bit
- sout_valid  output  1  sout carries a data bit
- frame  output  1  high while sout is bit 0 of a word
- done  output  1  one-cycle pulse after the last bit of a word is consumed

## Operation
- State: FSM {IDLE, SHIFT}; shift register sreg[WIDTH-1:0]; bit counter cnt (0..WIDTH-1); holding register hold[WIDTH-1:0] with flag hold_full.
- Reset (reset=0, async): state=IDLE, sreg=0, cnt=0, hold_full=0, done=0. Outputs while in reset: sout=0, sout_valid=0, frame=0, done=0, load_ready=0.
- load_ready = reset && !hold_full (combinational).
- sout = sreg[0]; sout_valid = (state==SHIFT); frame = (state==SHIFT && cnt==0).
- IDLE: on accept, sreg<=data, cnt<=0, state<=SHIFT; hold untouched.
- SHIFT, shift_en=0: all state frozen except accept into hold (hold<=data, hold_full<=1).
- SHIFT, shift_en=1, cnt<WIDTH-1: sreg<=sreg>>1, cnt<=cnt+1.
- SHIFT, shift_en=1, cnt==WIDTH-1 (last bit): done<=1 next cycle, then:
  - hold_full=1: sreg<=hold, hold_full<=0, cnt<=0, stay SHIFT; a same-cycle accept refills hold (hold_full stays 1).
  - hold_full=0 and accept this cycle: bypass, sreg<=data, cnt<=0, stay SHIFT; hold stays empty.
  - hold_full=0, no accept: state<=IDLE.
- SHIFT, accept with shift_en=0 or cnt<WIDTH-1: word goes to hold.
- done is registered; deasserts the following cycle unless another word completes.
- shift_en ignored in IDLE. data ignored unless accepted.

## Timing
- Accept in IDLE at edge N: sout_valid=1, frame=1, sout=data[0] from edge N onward.
- Bit k presented until the edge where shift_en=1 is sampled; word of WIDTH bits needs WIDTH enabled cycles.
- Back-to-back: with hold_full=1 (or a bypass accept) at the last-bit edge, bit 0 of the next word appears on the very next cycle; sout_valid never drops.
- done high for exactly the cycle after each last-bit edge.
- Reset asserted mid-word: all outputs clear immediately (async); partial word and held word discarded; first word after release starts at bit 0.
- Max throughput: one bit per cycle with shift_en held high and load_valid high.

## Test plan
- Reset: assert reset=0 mid-stream -> sout=0, sout_valid=0, frame=0, done=0, load_ready=0 immediately; after release load_ready=1, state IDLE.
- Single word: WIDTH=4, data=4'b1011, shift_en=1 -> sout 1,1,0,1 on 4 consecutive cycles, frame only on first, done pulse cycle 5, sout_valid=0 cycle 5.
- Stall: same word, shift_en low 2 cycles after bit 1 -> sout holds 1 for 3 cycles total, sequence otherwise 1,1,0,1, done still one pulse.
- Streaming: words 4'hA, 4'h5, 4'hF with load_valid high -> sout 0,1,0,1,1,0,1,0,1,1,1,1 with no gap, frame on bits 0,4,8, done pulses after bits 3,7,11; load_ready=0 while hold full.
- Backpressure: hold full, shift_en=0 -> load_ready=0, new data ignored; after last bit consumed, load_ready=1 next cycle.
- Bypass: hold empty, accept 4'h6 on same edge as last bit of 4'h9 -> next cycle frame=1, sout=0 (bit 0 of 4'h6), hold_full stays 0.
